// File: rtl/dcm_pkg.sv
// Shared constants and types for the digital clock manager and its program selector.
package dcm_pkg;

    localparam int PROG_W         = 3;
    localparam int DEBOUNCE_CNT_W = 24;

    // 10 ms at 100 MHz, matching the clock manager's COUNT_10 rate assumption
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    typedef logic [PROG_W-1:0] prog_t;

    // One staging step; opposing requests in the same cycle cancel out
    function automatic prog_t prog_step(input prog_t p, input logic up, input logic down);
        prog_t r;
        r = p;
        if (up && !down) begin
            r = p + prog_t'(1);
        end else if (down && !up) begin
            r = p - prog_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, stable-count debounce and a
// registered rising-edge pulse on the accepted level.
module btn_debounce
    import dcm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync_p0;
    logic                      sync_p1;
    logic                      level_q;
    logic [DEBOUNCE_CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0 <= raw;
            sync_p1 <= sync_p0;

            // any sample agreeing with the accepted level restarts the count
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // edge-detect stage boundary
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/prog_selector.sv
// Button-driven program code staging and commit strobe feeding the clock
// manager's prog_in / update_clock inputs.
module prog_selector
    import dcm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter prog_t       PROG_RESET      = 3'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_load,
    output logic [PROG_W-1:0] prog,
    output logic              update_clock,
    output logic [PROG_W-1:0] committed,
    output logic              pending
);

    logic up_level;
    logic down_level;
    logic load_level;
    logic up_press;
    logic down_press;
    logic load_press;
    logic hold_up;
    logic hold_down;
    logic step_up;
    logic step_down;
    logic unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clock (clock),
        .reset (reset),
        .raw   (btn_up),
        .level (up_level),
        .press (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clock (clock),
        .reset (reset),
        .raw   (btn_down),
        .level (down_level),
        .press (down_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clock (clock),
        .reset (reset),
        .raw   (btn_load),
        .level (load_level),
        .press (load_press)
    );

    assign unused_levels = up_level ^ down_level ^ load_level;

    // A step deferred past a strobe is replayed alongside any fresh event
    assign step_up   = up_press | hold_up;
    assign step_down = down_press | hold_down;

    always_ff @(posedge clock) begin
        if (reset) begin
            prog         <= PROG_RESET;
            committed    <= PROG_RESET;
            update_clock <= 1'b0;
            pending      <= 1'b0;
            hold_up      <= 1'b0;
            hold_down    <= 1'b0;
        end else begin
            update_clock <= load_press;
            pending      <= (prog != committed);

            // prog is frozen on the edge that raises the strobe so the
            // clock manager's level-sensitive capture sees a stable code
            if (load_press) begin
                committed <= prog;
                hold_up   <= step_up;
                hold_down <= step_down;
            end else begin
                prog      <= prog_step(prog, step_up, step_down);
                hold_up   <= 1'b0;
                hold_down <= 1'b0;
            end
        end
    end

endmodule
